// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - toggle-encoded event line to pulse plus saturating handshake counter
module toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tin,
    output logic             pulse,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic             ovf
);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ACC_MAX  = '1;
    localparam logic [CNT_W-1:0] ACC_ONE  = CNT_W'(1);
    localparam logic [2:0]       ARM_LAST = 3'(SYNC_STAGES);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [2:0]             arm_q, arm_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   pulse_q;

    logic                   edge_det;
    logic                   hs;

    // Either polarity of transition at the synchroniser output is one event.
    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign hs       = (state_q == PEND) & rd_ready;

    // Next-state, accumulator and overflow decisions.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            ARM: begin
                // Let the chain and prev settle on the current tin level.
                acc_d = '0;
                ovf_d = 1'b0;
                if (arm_q == ARM_LAST) begin
                    state_d = IDLE;
                end else begin
                    arm_d = arm_q + 3'd1;
                end
            end
            IDLE: begin
                if (edge_det) begin
                    acc_d   = ACC_ONE;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (hs && edge_det) begin
                    // Consumer takes the old count; the new event starts afresh.
                    acc_d = ACC_ONE;
                    ovf_d = 1'b0;
                end else if (hs) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end else if (edge_det) begin
                    if (acc_q == ACC_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_q + ACC_ONE;
                    end
                end
            end
            default: begin
                state_d = ARM;
                arm_d   = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Falling-edge state register, synchroniser and registered pulse.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ARM;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            arm_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q[0] <= tin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q  <= sync_q[SYNC_STAGES-1];
            state_q <= state_d;
            arm_q   <= arm_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            pulse_q <= edge_det & (state_q != ARM);
        end
    end

    assign pulse    = pulse_q;
    assign rd_valid = (state_q == PEND);
    assign rd_count = acc_q;
    assign ovf      = ovf_q;

endmodule
